// File: rtl/sys_tick_master.sv
// sys_tick_master: Avalon-MM initiator that arms an interval timer and turns each serviced timeout into a tick pulse and count
module sys_tick_master #(
    parameter int         TICK_W       = 32,
    parameter int         READ_LATENCY = 1,
    parameter logic [2:0] STATUS_ADDR  = 3'd0,
    parameter logic [2:0] CTRL_ADDR    = 3'd1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic              read_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              waitrequest,
    input  logic              irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              spurious,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, WR_CTRL, WAIT_IRQ, RD_STAT, RD_WAIT, WR_CLR, GUARD, WR_DIS} state_t;

    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

    state_t            state_q;
    logic [1:0]        lat_q;
    logic [2:0]        address_q;
    logic              chipselect_q;
    logic              write_n_q;
    logic              read_n_q;
    logic [15:0]       writedata_q;
    logic              tick_q;
    logic [TICK_W-1:0] tick_count_q;
    logic              spurious_q;
    logic              busy_q;
    logic              unused_rd;

    assign unused_rd  = ^readdata[15:1];
    assign address    = address_q;
    assign chipselect = chipselect_q;
    assign write_n    = write_n_q;
    assign read_n     = read_n_q;
    assign writedata  = writedata_q;
    assign tick       = tick_q;
    assign tick_count = tick_count_q;
    assign spurious   = spurious_q;
    assign busy       = busy_q;

    // Service FSM; bus strobes are launched on the transition into each access state so every output is registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lat_q        <= 2'd0;
            address_q    <= 3'd0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            read_n_q     <= 1'b1;
            writedata_q  <= 16'h0000;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            spurious_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            spurious_q <= 1'b0;
            case (state_q)
                IDLE: if (enable) begin
                    state_q      <= WR_CTRL;
                    chipselect_q <= 1'b1;
                    write_n_q    <= 1'b0;
                    address_q    <= CTRL_ADDR;
                    writedata_q  <= 16'h0001;
                    busy_q       <= 1'b1;
                end
                WR_CTRL: if (!waitrequest) begin
                    state_q      <= WAIT_IRQ;
                    chipselect_q <= 1'b0;
                    write_n_q    <= 1'b1;
                    busy_q       <= 1'b0;
                end
                WAIT_IRQ: if (!enable) begin
                    state_q      <= WR_DIS;
                    chipselect_q <= 1'b1;
                    write_n_q    <= 1'b0;
                    address_q    <= CTRL_ADDR;
                    writedata_q  <= 16'h0000;
                    busy_q       <= 1'b1;
                end else if (irq) begin
                    state_q      <= RD_STAT;
                    chipselect_q <= 1'b1;
                    read_n_q     <= 1'b0;
                    address_q    <= STATUS_ADDR;
                    busy_q       <= 1'b1;
                end
                RD_STAT: if (!waitrequest) begin
                    state_q      <= RD_WAIT;
                    chipselect_q <= 1'b0;
                    read_n_q     <= 1'b1;
                    lat_q        <= LAT_M1;
                end
                RD_WAIT: if (lat_q == 2'd0) begin
                    state_q      <= WR_CLR;
                    tick_q       <= readdata[0];
                    spurious_q   <= ~readdata[0];
                    tick_count_q <= readdata[0] ? tick_count_q + TICK_W'(1) : tick_count_q;
                    chipselect_q <= 1'b1;
                    write_n_q    <= 1'b0;
                    address_q    <= STATUS_ADDR;
                    writedata_q  <= 16'h0000;
                end else begin
                    lat_q <= lat_q - 2'd1;
                end
                WR_CLR: if (!waitrequest) begin
                    state_q      <= GUARD;
                    chipselect_q <= 1'b0;
                    write_n_q    <= 1'b1;
                end
                GUARD: begin
                    state_q <= WAIT_IRQ;
                    busy_q  <= 1'b0;
                end
                WR_DIS: if (!waitrequest) begin
                    state_q      <= IDLE;
                    chipselect_q <= 1'b0;
                    write_n_q    <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_tick_master.sv
// tb_sys_tick_master: directed bench with a timer-slave model for sys_tick_master
module tb_sys_tick_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        irq;
    logic        tick;
    logic [3:0]  tick_count;
    logic        spurious;
    logic        busy;

    logic        tmo = 1'b0;
    logic        ie = 1'b0;
    logic        irq_q = 1'b0;
    logic [15:0] rdata_q = 16'h0000;
    logic        fire_req = 1'b0;
    logic        force_irq = 1'b0;
    int          ws_n = 0;
    int          ws_cnt = 0;

    int n_chk = 0, n_err = 0;
    int n_rd = 0, n_wr_on = 0, n_wr_off = 0, n_wr_clr = 0;
    int n_tick = 0, n_spur = 0, last_tc = -1, hl = 0;
    logic        prev_tick = 1'b0, prev_spur = 1'b0, pend = 1'b0;
    logic [21:0] saved = '0;

    sys_tick_master #(.TICK_W(4), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .address(address),
        .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
        .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
        .irq(irq), .tick(tick), .tick_count(tick_count), .spurious(spurious), .busy(busy)
    );

    always #5 clk = ~clk;

    assign waitrequest = chipselect && (ws_cnt < ws_n);
    assign readdata    = rdata_q;
    assign irq         = irq_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timer slave: status {running=1, timeout}, control {ie}; irq registered so it drops one cycle after the clear
    always @(posedge clk) begin
        if (chipselect && !waitrequest) begin
            if (!write_n && address == 3'd1) ie <= writedata[0];
            if (!write_n && address == 3'd0) tmo <= 1'b0;
            if (!read_n) rdata_q <= {14'd0, 1'b1, tmo};
        end
        if (fire_req) tmo <= 1'b1;
        irq_q  <= (tmo & ie) | force_irq;
        ws_cnt <= (chipselect && waitrequest) ? ws_cnt + 1 : 0;
    end

    // Bus and pulse monitor
    always @(posedge clk) begin
        if (!reset_n) begin
            pend = 1'b0;
            hl   = 0;
        end else begin
            if (pend) chk("hold_stable", {10'd0, chipselect, write_n, read_n, address, writedata}, {10'd0, saved});
            pend  = chipselect && waitrequest;
            saved = {chipselect, write_n, read_n, address, writedata};
            if (chipselect) begin
                chk("one_strobe", write_n ^ read_n, 1);
                hl++;
                if (!waitrequest) begin
                    chk("hold_len", hl, ws_n + 1);
                    hl = 0;
                    if (!read_n) begin
                        n_rd++;
                        chk("rd_addr", address, 0);
                    end else if (address == 3'd1 && writedata == 16'h0001) n_wr_on++;
                    else if (address == 3'd1 && writedata == 16'h0000) n_wr_off++;
                    else if (address == 3'd0 && writedata == 16'h0000) n_wr_clr++;
                    else chk("wr_target", {13'd0, address, writedata}, 32'hFFFF_FFFF);
                end
            end else hl = 0;
            if (tick) begin
                n_tick++;
                last_tc = int'(tick_count);
                chk("tick_width", prev_tick, 0);
            end
            if (spurious) begin
                n_spur++;
                chk("spur_width", prev_spur, 0);
                chk("spur_no_tick", tick, 0);
            end
            prev_tick = tick;
            prev_spur = spurious;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic service();
        int t0;
        t0 = n_tick;
        fire_req = 1'b1;
        cyc();
        fire_req = 1'b0;
        for (int i = 0; i < 40 && n_tick == t0; i++) cyc();
        chk("svc_done", n_tick, t0 + 1);
        repeat (10) cyc();
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_cs", chipselect, 0);
        chk("rst_wn", write_n, 1);
        chk("rst_rn", read_n, 1);
        chk("rst_addr", address, 0);
        chk("rst_wd", writedata, 0);
        chk("rst_tick", tick, 0);
        chk("rst_cnt", tick_count, 0);
        chk("rst_spur", spurious, 0);
        chk("rst_busy", busy, 0);

        reset_n = 1'b1;
        enable  = 1'b1;
        cyc();
        chk("arm_cs", chipselect, 1);
        chk("arm_wn", write_n, 0);
        chk("arm_rn", read_n, 1);
        chk("arm_addr", address, 1);
        chk("arm_wd", writedata, 16'h0001);
        chk("arm_busy", busy, 1);
        cyc();
        chk("arm_done_cs", chipselect, 0);
        chk("arm_done_wn", write_n, 1);
        chk("arm_done_busy", busy, 0);
        chk("arm_count", n_wr_on, 1);

        fire_req = 1'b1;
        cyc();
        fire_req = 1'b0;
        cyc();
        cyc();
        chk("rd_cs", chipselect, 1);
        chk("rd_rn", read_n, 0);
        chk("rd_wn", write_n, 1);
        chk("rd_addr_o", address, 0);
        chk("rd_busy", busy, 1);
        cyc();
        chk("rdw_cs", chipselect, 0);
        chk("rdw_tick", tick, 0);
        cyc();
        chk("svc_tick", tick, 1);
        chk("svc_cnt", tick_count, 1);
        chk("clr_cs", chipselect, 1);
        chk("clr_wn", write_n, 0);
        chk("clr_addr", address, 0);
        chk("clr_wd", writedata, 0);
        cyc();
        chk("guard_tick", tick, 0);
        chk("guard_cs", chipselect, 0);
        chk("guard_busy", busy, 1);
        cyc();
        chk("wait_busy", busy, 0);
        repeat (4) cyc();
        chk("svc1_reads", n_rd, 1);
        chk("svc1_clrs", n_wr_clr, 1);
        chk("svc1_cnt", tick_count, 1);

        ws_n = 3;
        service();
        ws_n = 0;
        chk("ws_reads", n_rd, 2);
        chk("ws_clrs", n_wr_clr, 2);
        chk("ws_ticks", n_tick, 2);
        chk("ws_cnt", tick_count, 2);

        force_irq = 1'b1;
        cyc();
        force_irq = 1'b0;
        for (int i = 0; i < 40 && n_spur == 0; i++) cyc();
        repeat (8) cyc();
        chk("spur_seen", n_spur, 1);
        chk("spur_ticks", n_tick, 2);
        chk("spur_cnt", tick_count, 2);
        chk("spur_clrs", n_wr_clr, 3);

        for (int k = 0; k < 13; k++) service();
        chk("pre_wrap_cnt", tick_count, 15);
        service();
        chk("wrap_cnt", tick_count, 0);
        chk("wrap_tick_cnt", last_tc, 0);

        fire_req = 1'b1;
        cyc();
        fire_req = 1'b0;
        cyc();
        cyc();
        chk("dis_rd_rn", read_n, 0);
        cyc();
        enable = 1'b0;
        cyc();
        chk("dis_tick", tick, 1);
        chk("dis_cnt", tick_count, 1);
        cyc();
        cyc();
        chk("dis_wait_cs", chipselect, 0);
        cyc();
        chk("dis_cs", chipselect, 1);
        chk("dis_wn", write_n, 0);
        chk("dis_addr", address, 1);
        chk("dis_wd", writedata, 0);
        chk("dis_busy", busy, 1);
        cyc();
        chk("idle_cs", chipselect, 0);
        chk("idle_busy", busy, 0);
        repeat (5) cyc();
        chk("dis_writes", n_wr_off, 1);
        chk("dis_idle_cs", chipselect, 0);
        chk("dis_hold_cnt", tick_count, 1);

        ws_n   = 3;
        enable = 1'b1;
        cyc();
        chk("mid_cs", chipselect, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_cs", chipselect, 0);
        chk("abort_wn", write_n, 1);
        chk("abort_addr", address, 0);
        chk("abort_wd", writedata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", tick_count, 0);
        repeat (3) cyc();
        chk("abort_no_acc", n_wr_on, 1);
        enable  = 1'b0;
        ws_n    = 0;
        reset_n = 1'b1;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
